operand_entry_regs: RTL

Parametrised operand entry and storage block for the hex calculator datapath. It sits between the keypad decoder and the ALU. It builds the current operand (`v1`) digit by digit from keypad pulses and supports backspace, clear and sign toggle. A DEPTH-entry operand stack holds earlier operands, and its top drives `v2`. ALU results are loaded back into `v1` on equals. All values are sign-magnitude: bit W is the sign, bits W-1:0 the magnitude.

---
 rtl/calc_pkg.sv | 38 +++
 rtl/operand_stack.sv | 61 ++++++
 rtl/operand_entry_regs.sv | 125 ++++++++++++
 3 files changed

// File: rtl/calc_pkg.sv
// Shared types and sign-magnitude helpers for the hex calculator datapath.
// Values are {sign, magnitude}; helpers take a zero-extended value plus the real magnitude width.
package calc_pkg;

  localparam int DIGIT_W    = 4;
  localparam int MAX_DIGITS = 16;
  localparam int MAX_W      = DIGIT_W * MAX_DIGITS;

  typedef enum logic {
    ENTRY = 1'b0,
    FLOW  = 1'b1
  } entry_state_e;

  // Magnitude of a w-bit sign-magnitude value (the sign sits at bit w and is dropped).
  function automatic logic [MAX_W-1:0] sm_mag(input logic [MAX_W:0] sm, input int w);
    logic [MAX_W-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_W; i++) begin
      if (i < w) m[i] = sm[i];
    end
    return m;
  endfunction

  function automatic logic sm_is_zero(input logic [MAX_W:0] sm, input int w);
    return sm_mag(sm, w) == '0;
  endfunction

  // Number of hex digits left once leading zeros are stripped; 0 for a zero magnitude.
  function automatic int sig_digits(input logic [MAX_W-1:0] mag, input int digits);
    int n;
    n = 0;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (i < digits && mag[DIGIT_W*i +: DIGIT_W] != '0) n = i + 1;
    end
    return n;
  endfunction

endpackage

// File: rtl/operand_stack.sv
// DEPTH-entry LIFO of sign-magnitude operands; a push when full drops the oldest
// entry and sets the sticky ovf flag. top reads 0 while the stack is empty.
module operand_stack #(
  parameter  int DEPTH = 2,
  parameter  int WIDTH = 17,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] top,
  output logic [CW-1:0]    cnt,
  output logic             ovf
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [CW-1:0]    cnt_q;
  logic             ovf_q;
  logic             full;

  assign full = (cnt_q == CW'(DEPTH));

  // NOTE: storage has no reset; cnt_q alone decides which entries are visible.
  always_ff @(posedge clock) begin
    if (push) begin
      if (full) begin
        for (int i = 0; i < DEPTH - 1; i++) mem_q[i] <= mem_q[i+1];
        mem_q[DEPTH-1] <= din;
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          if (CW'(i) == cnt_q) mem_q[i] <= din;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else if (push) begin
      if (full) ovf_q <= 1'b1;
      else      cnt_q <= cnt_q + CW'(1);
    end else if (pop && cnt_q != '0) begin
      cnt_q <= cnt_q - CW'(1);
    end
  end

  always_comb begin
    top = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (cnt_q == CW'(i + 1)) top = mem_q[i];
    end
  end

  assign cnt = cnt_q;
  assign ovf = ovf_q;

endmodule

// File: rtl/operand_entry_regs.sv
// Operand entry registers: builds v1 from keypad digits, keeps earlier operands on a stack.
// Define OPERAND_SIGN_EN to enable the neg (sign toggle) key; otherwise typed digits are positive.
module operand_entry_regs
  import calc_pkg::*;
#(
  parameter  int DIGITS = 4,
  parameter  int DEPTH  = 2,
  localparam int W      = DIGIT_W * DIGITS,
  localparam int NW     = $clog2(DIGITS + 1),
  localparam int CW     = $clog2(DEPTH + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          newhex,
  input  logic [3:0]    hexcode,
  input  logic          newop,
  input  logic          eq,
  input  logic          bs,
  input  logic          clr,
  input  logic          neg,
  input  logic [W:0]    answer,
  output logic [W:0]    v1,
  output logic [W:0]    v2,
  output logic [NW-1:0] ndigits,
  output logic          entry_full,
  output logic          flow,
  output logic [CW-1:0] stack_cnt,
  output logic          stack_ovf
);

  localparam int SMW = MAX_W + 1;

  entry_state_e  state_q, state_d;
  logic [W:0]    v1_q, v1_d;
  logic [NW-1:0] nd_q, nd_d;
  logic          full_q;
  logic          push, pop;

  logic [W-1:0]  mag_q, mag_bs, mag_hex;
  logic          sign_q;

  assign mag_q   = W'(sm_mag(SMW'(v1_q), W));
  assign sign_q  = v1_q[W];
  assign mag_bs  = mag_q >> DIGIT_W;
  assign mag_hex = (mag_q << DIGIT_W) | W'(hexcode);

  // NOTE: every output of this block gets a default first, so no path infers a latch.
  always_comb begin
    state_d = state_q;
    v1_d    = v1_q;
    nd_d    = nd_q;
    push    = 1'b0;
    pop     = 1'b0;
    if (eq) begin
      v1_d    = answer;
      nd_d    = NW'(sig_digits(sm_mag(SMW'(answer), W), DIGITS));
      pop     = 1'b1;
      state_d = FLOW;
    end else if (newop) begin
      push    = 1'b1;
      state_d = FLOW;
    end else if (clr) begin
      v1_d    = '0;
      nd_d    = '0;
      state_d = ENTRY;
    end else if (bs) begin
      v1_d    = {sign_q & !sm_is_zero(SMW'(mag_bs), W), mag_bs};
      nd_d    = (nd_q == '0) ? '0 : nd_q - NW'(1);
      state_d = ENTRY;
    end else if (neg) begin
`ifdef OPERAND_SIGN_EN
      if (!sm_is_zero(SMW'(v1_q), W)) v1_d = {~sign_q, mag_q};
`endif
    end else if (newhex) begin
      if (state_q == FLOW) begin
        v1_d    = {1'b0, W'(hexcode)};
        nd_d    = NW'(hexcode != 4'h0);
        state_d = ENTRY;
      end else if (!full_q) begin
`ifdef OPERAND_SIGN_EN
        v1_d = {sign_q, mag_hex};
`else
        v1_d = {1'b0, mag_hex};
`endif
        // A leading zero typed into an empty entry leaves the digit count alone.
        if (!(nd_q == '0 && hexcode == 4'h0)) nd_d = nd_q + NW'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ENTRY;
      v1_q    <= '0;
      nd_q    <= '0;
      full_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      v1_q    <= v1_d;
      nd_q    <= nd_d;
      full_q  <= (nd_d == NW'(DIGITS));
    end
  end

  operand_stack #(
    .DEPTH (DEPTH),
    .WIDTH (W + 1)
  ) u_stack (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (v1_q),
    .top   (v2),
    .cnt   (stack_cnt),
    .ovf   (stack_ovf)
  );

  assign v1         = v1_q;
  assign ndigits    = nd_q;
  assign entry_full = full_q;
  assign flow       = (state_q == FLOW);

endmodule
